// File: rtl/axi_lite_master_if.sv
// Core-side request/response and AXI4-Lite bus bundle for axi_lite_master.
// The master modport is the initiator's view; the slave modport is the environment's.
interface axi_lite_master_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic              req_valid;
    logic              req_ready;
    logic              req_wen;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [STRB_W-1:0] req_wstrb;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    logic              ARVALID;
    logic              ARREADY;
    logic [ADDR_W-1:0] ARADDR;
    logic              RVALID;
    logic              RREADY;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              AWVALID;
    logic              AWREADY;
    logic [ADDR_W-1:0] AWADDR;
    logic              WVALID;
    logic              WREADY;
    logic [DATA_W-1:0] WDATA;
    logic [STRB_W-1:0] WSTRB;
    logic              BVALID;
    logic              BREADY;
    logic [1:0]        BRESP;

    modport master (
        input  req_valid, req_wen, req_addr, req_wdata, req_wstrb, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err,
        input  ARREADY, RVALID, RDATA, RRESP, AWREADY, WREADY, BVALID, BRESP,
        output ARVALID, ARADDR, RREADY, AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY
    );

    modport slave (
        output req_valid, req_wen, req_addr, req_wdata, req_wstrb, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        output ARREADY, RVALID, RDATA, RRESP, AWREADY, WREADY, BVALID, BRESP,
        input  ARVALID, ARADDR, RREADY, AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY
    );
endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator: one core load/store becomes one bus transaction,
// with read data and an error flag returned to the core.
module axi_lite_master #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input logic               clk,
    input logic               rst,
    axi_lite_master_if.master bus
);
    localparam int unsigned STRB_W = DATA_W / 8;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StWrite = 3'd1;
    localparam logic [2:0] StB     = 3'd2;
    localparam logic [2:0] StAr    = 3'd3;
    localparam logic [2:0] StR     = 3'd4;
    localparam logic [2:0] StResp  = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic aw_hs;
    logic w_hs;

    // Only xRESP[1] distinguishes an error; bit 0 (EXOKAY/DECERR split) is not needed.
    logic unused_resp_lsb;
    assign unused_resp_lsb = bus.RRESP[0] ^ bus.BRESP[0];

    assign aw_hs = (state_q == StWrite) && !aw_done_q && bus.AWREADY;
    assign w_hs  = (state_q == StWrite) && !w_done_q && bus.WREADY;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    addr_d = bus.req_addr;
                    if (bus.req_wen) begin
                        wdata_d   = bus.req_wdata;
                        wstrb_d   = bus.req_wstrb;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = StWrite;
                    end else begin
                        state_d = StAr;
                    end
                end
            end
            StWrite: begin
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs)  w_done_d  = 1'b1;
                // Leave as soon as both channels are through, counting this cycle's handshakes.
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = StB;
            end
            StB: begin
                if (bus.BVALID) begin
                    err_d   = bus.BRESP[1];
                    rdata_d = '0;
                    state_d = StResp;
                end
            end
            StAr: begin
                if (bus.ARREADY) state_d = StR;
            end
            StR: begin
                if (bus.RVALID) begin
                    rdata_d = bus.RDATA;
                    err_d   = bus.RRESP[1];
                    state_d = StResp;
                end
            end
            StResp: begin
                if (bus.resp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    // All bus outputs are pure functions of registered state.
    assign bus.req_ready  = (state_q == StIdle);
    assign bus.resp_valid = (state_q == StResp);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

    assign bus.AWVALID = (state_q == StWrite) && !aw_done_q;
    assign bus.AWADDR  = addr_q;
    assign bus.WVALID  = (state_q == StWrite) && !w_done_q;
    assign bus.WDATA   = wdata_q;
    assign bus.WSTRB   = wstrb_q;
    assign bus.BREADY  = (state_q == StB);
    assign bus.ARVALID = (state_q == StAr);
    assign bus.ARADDR  = addr_q;
    assign bus.RREADY  = (state_q == StR);
endmodule

// File: doc/axi_lite_master.md
Name: axi_lite_master

Overview:
- Single-outstanding AXI4-Lite initiator that turns a simple core-side load/store request into one AXI4-Lite read or write transaction.
- Returns read data and an error flag to the core.
- Sits between the LSU/IFU and memory-mapped responders such as the UART and the SRAM model.
- Issues AW and W together and tolerates any responder ordering of their handshakes.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; WSTRB width is DATA_W/8

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  reset, asynchronous, active-low (rst=0 resets)
req_valid  in  1  core request valid
req_ready  out  1  block can accept a request
req_wen  in  1  1=write, 0=read
req_addr  in  ADDR_W  request address
req_wdata  in  DATA_W  write data
req_wstrb  in  DATA_W/8  write byte strobes
resp_valid  out  1  completion valid
resp_ready  in  1  core accepts completion
resp_rdata  out  DATA_W  read data (0 for writes)
resp_err  out  1  1 when xRESP[1]=1 (SLVERR/DECERR)
ARVALID  out  1  read address valid
ARREADY  in  1  read address ready
ARADDR  out  ADDR_W  read address
RVALID  in  1  read data valid
RREADY  out  1  read data ready
RDATA  in  DATA_W  read data
RRESP  in  2  read response
AWVALID  out  1  write address valid
AWREADY  in  1  write address ready
AWADDR  out  ADDR_W  write address
WVALID  out  1  write data valid
WREADY  in  1  write data ready
WDATA  out  DATA_W  write data
WSTRB  out  DATA_W/8  write strobes
BVALID  in  1  write response valid
BREADY  out  1  write response ready
BRESP  in  2  write response

Behaviour:
- Reset (rst=0, asynchronous):
  - State returns to IDLE immediately.
  - All *VALID and *READY outputs are 0, except req_ready=1.
  - resp_valid=0, resp_err=0.
  - resp_rdata and the address/data registers are cleared to 0.
  - A reset asserted mid-transaction abandons that transaction with no completion.
- req_ready=1 only in IDLE.
- On req_valid & req_ready, latch addr/wdata/wstrb/wen.
- Next state: WRITE if wen=1, else AR.
- States:
  - IDLE: wait for a request.
  - WRITE: AWVALID=~aw_done, WVALID=~w_done.
    - aw_done sets on AWVALID&AWREADY; w_done sets on WVALID&WREADY.
    - Both handshakes may complete in the same cycle.
    - When both are done (including the completing cycle), go to B.
    - Flags clear on entry to WRITE.
  - B: BREADY=1. On BVALID, capture resp_err=BRESP[1], set resp_rdata=0, go to RESP.
  - AR: ARVALID=1. On ARREADY, go to R.
  - R: RREADY=1. On RVALID, capture resp_rdata=RDATA and resp_err=RRESP[1], go to RESP.
  - RESP: resp_valid=1; hold resp_rdata and resp_err stable. On resp_ready, go to IDLE.
- AXI rules:
  - A VALID, once raised, stays high with stable address/data/strobes until its READY.
  - A VALID never depends combinationally on any READY.
  - BREADY and RREADY are high only in B and R respectively.
- Output addresses and data always come from the latched registers, never from req_* inputs.
- WSTRB is ignored on reads.
- A write with req_wstrb=0 is still issued on the bus.
- Latency, zero-wait responder:
  - Write: accept at cycle 0, AW/W handshake at cycle 1, B at cycle 2, resp_valid at cycle 3.
  - Read: accept at 0, AR at 1, R at 2, resp_valid at 3.
- Exactly one transaction is outstanding; no new request is accepted until the completion is consumed.
- BVALID/RVALID arriving in an unexpected state are ignored (READY is low).

Test Plan:
- Reset: hold rst=0 three cycles with random inputs -> all VALID/READY outputs 0, req_ready=1, resp_valid=0. Release -> still idle with no bus activity.
- Zero-wait write: addr 0x1000_0000, data 0x0000_0041, wstrb 0001; AWREADY=WREADY=1; BVALID one cycle after, BRESP=00 -> AWVALID and WVALID high exactly cycle 1 with AWADDR=0x1000_0000, WDATA=0x41, WSTRB=0001; BREADY at cycle 2; resp_valid at cycle 3; resp_err=0, resp_rdata=0.
- Split write handshake: AWREADY at cycle 1, WREADY only at cycle 4 -> AWVALID drops after cycle 1; WVALID and WDATA stay stable through cycle 4; BREADY rises at cycle 5. Repeat with WREADY first -> symmetric behaviour.
- Delayed read with error: ARREADY after 2 cycles; RVALID 5 cycles after AR handshake with RDATA=0xDEAD_BEEF, RRESP=10 -> ARADDR stable while waiting; RREADY high throughout R; resp_rdata=0xDEAD_BEEF, resp_err=1.
- Completion back-pressure: resp_ready=0 for 4 cycles while req_valid=1 with a new request -> resp_valid held with data stable, req_ready=0, no AR/AW/W activity. Second request accepted the cycle after resp_ready=1.
- Reset mid-transaction: drive rst=0 while in B (BVALID not yet given) -> BREADY and all outputs drop immediately (asynchronously). After release, req_ready=1 and no resp_valid ever appears for the abandoned write.
